// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer with expiry buzzer request.
// Decrements once per 1 Hz tick while running; expiry holds 00:00 and buzzes for BUZZ_TICKS ticks.
module countdown_timer #(
  parameter int MAX_MIN    = 99,
  parameter int BUZZ_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [6:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] min_out,
  output logic [6:0] sec_out,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       buzz
);

  localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);
  localparam logic [6:0] BUZZ_L    = 7'(BUZZ_TICKS);
  localparam logic [6:0] SEC_MAX   = 7'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [6:0] min_reg, min_next;
  logic [6:0] sec_reg, sec_next;
  logic [6:0] bcnt_reg, bcnt_next;
  logic       buzz_reg, buzz_next;
  logic       running_reg, paused_reg, done_reg;
  logic       count_zero;
  logic       last_second;

  assign count_zero  = (min_reg == 7'd0) && (sec_reg == 7'd0);
  assign last_second = (min_reg == 7'd0) && (sec_reg == 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      min_reg     <= 7'd0;
      sec_reg     <= 7'd0;
      bcnt_reg    <= 7'd0;
      buzz_reg    <= 1'b0;
      running_reg <= 1'b0;
      paused_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      min_reg     <= min_next;
      sec_reg     <= sec_next;
      bcnt_reg    <= bcnt_next;
      buzz_reg    <= buzz_next;
      // Status flags are registered copies of the next state so they change on the same edge.
      running_reg <= (state_next == RUN);
      paused_reg  <= (state_next == PAUSED);
      done_reg    <= (state_next == EXPIRED);
    end
  end

  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    bcnt_next  = bcnt_reg;
    buzz_next  = buzz_reg;

    if (load) begin
      state_next = IDLE;
      buzz_next  = 1'b0;
      bcnt_next  = 7'd0;
      min_next   = (load_min > MAX_MIN_L) ? MAX_MIN_L : load_min;
      sec_next   = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !count_zero) begin
            state_next = RUN;
          end
        end

        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (tick) begin
            // A stray 00:00 in RUN is treated as expiry so the count can never underflow.
            if (last_second || count_zero) begin
              min_next   = 7'd0;
              sec_next   = 7'd0;
              state_next = EXPIRED;
              buzz_next  = 1'b1;
              bcnt_next  = 7'd0;
            end else if (sec_reg != 7'd0) begin
              sec_next = sec_reg - 7'd1;
            end else begin
              sec_next = SEC_MAX;
              min_next = min_reg - 7'd1;
            end
          end
        end

        PAUSED: begin
          if (start) begin
            state_next = RUN;
          end
        end

        EXPIRED: begin
          if (start || pause) begin
            state_next = IDLE;
            min_next   = 7'd0;
            sec_next   = 7'd0;
            buzz_next  = 1'b0;
            bcnt_next  = 7'd0;
          end else if (tick && buzz_reg) begin
            bcnt_next = bcnt_reg + 7'd1;
            if ((bcnt_reg + 7'd1) == BUZZ_L) begin
              buzz_next = 1'b0;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign min_out = min_reg;
  assign sec_out = sec_reg;
  assign running = running_reg;
  assign paused  = paused_reg;
  assign done    = done_reg;
  assign buzz    = buzz_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer: each vector's expectation goes through a scoreboard
// queue and is popped after the edge; async reset cases are hand-written sequences.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, load, start, pause;
  logic [6:0] load_min, load_sec;
  logic [6:0] min_out, sec_out;
  logic       running, paused, done, buzz;

  always #5 clk = ~clk;

  countdown_timer #(.MAX_MIN(99), .BUZZ_TICKS(10)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause),
    .min_out(min_out), .sec_out(sec_out),
    .running(running), .paused(paused), .done(done), .buzz(buzz)
  );

  typedef struct {
    string      name;
    logic       ld;
    logic [6:0] lm, ls;
    logic       st, pa, tk;
    logic [17:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [17:0] pack_exp(int m, int s, bit r, bit p, bit d, bit b);
    return {7'(m), 7'(s), r, p, d, b};
  endfunction

  task automatic add(string n, bit ld, int lm, int ls, bit st, bit pa, bit tk,
                     int em, int es, bit er, bit ep, bit ed, bit eb);
    vec_t v;
    v.name = n; v.ld = ld; v.lm = 7'(lm); v.ls = 7'(ls);
    v.st = st; v.pa = pa; v.tk = tk;
    v.exp = pack_exp(em, es, er, ep, ed, eb);
    tbl.push_back(v);
  endtask

  task automatic check(string n, logic [17:0] exp);
    logic [17:0] act;
    act = {min_out, sec_out, running, paused, done, buzz};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d:%0d r=%b p=%b d=%b b=%b, want %0d:%0d r=%b p=%b d=%b b=%b",
               n, act[17:11], act[10:4], act[3], act[2], act[1], act[0],
               exp[17:11], exp[10:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, want one pending entry");
    end else begin
      e = sb.pop_front();
      check(e.name, e.exp);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    load = v.ld; load_min = v.lm; load_sec = v.ls;
    start = v.st; pause = v.pa; tick = v.tk;
    e.name = v.name; e.exp = v.exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check();
    $display("vec %-14s ld=%b st=%b pa=%b tk=%b -> %0d:%0d r=%b p=%b d=%b b=%b",
             v.name, v.ld, v.st, v.pa, v.tk, min_out, sec_out, running, paused, done, buzz);
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 0; load = 0; start = 0; pause = 0; load_min = 0; load_sec = 0;
    #12;
    check("reset", pack_exp(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    //   name          ld lm  ls st pa tk  em  es r p d b
    add("idle_start0", 0, 0,  0, 1, 0, 0,   0,  0, 0,0,0,0);
    add("idle_pause",  0, 0,  0, 0, 1, 1,   0,  0, 0,0,0,0);
    add("load_0100",   1, 1,  0, 0, 0, 0,   1,  0, 0,0,0,0);
    add("idle_tick",   0, 0,  0, 0, 0, 1,   1,  0, 0,0,0,0);
    add("start_0100",  0, 0,  0, 1, 0, 0,   1,  0, 1,0,0,0);
    add("borrow",      0, 0,  0, 0, 0, 1,   0, 59, 1,0,0,0);
    add("dec_58",      0, 0,  0, 0, 0, 1,   0, 58, 1,0,0,0);
    add("dec_57",      0, 0,  0, 0, 0, 1,   0, 57, 1,0,0,0);
    add("no_tick",     0, 0,  0, 0, 0, 0,   0, 57, 1,0,0,0);
    add("load_0002",   1, 0,  2, 0, 0, 0,   0,  2, 0,0,0,0);
    add("start_0002",  0, 0,  0, 1, 0, 1,   0,  2, 1,0,0,0);
    add("dec_01",      0, 0,  0, 0, 0, 1,   0,  1, 1,0,0,0);
    add("expire",      0, 0,  0, 0, 0, 1,   0,  0, 0,0,1,1);
    run_table();
    for (int i = 1; i <= 10; i++)
      add($sformatf("buzz_tick%0d", i), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, (i < 10));
    add("buzz_after",  0, 0,  0, 0, 0, 1,   0,  0, 0,0,1,0);
    add("ack_start",   0, 0,  0, 1, 0, 0,   0,  0, 0,0,0,0);
    add("idle0_start", 0, 0,  0, 1, 0, 1,   0,  0, 0,0,0,0);
    add("clamp_load",  1, 120, 75, 0, 0, 0, 99, 59, 0,0,0,0);
    add("clamp_start", 0, 0,  0, 1, 0, 0,  99, 59, 1,0,0,0);
    add("clamp_dec",   0, 0,  0, 0, 0, 1,  99, 58, 1,0,0,0);
    add("clamp_max",   1, 127, 127, 0, 0, 0, 99, 59, 0,0,0,0);
    add("load_edge",   1, 99, 59, 0, 0, 0,  99, 59, 0,0,0,0);
    add("load_0230",   1, 2, 30, 0, 0, 0,   2, 30, 0,0,0,0);
    add("run_0230",    0, 0,  0, 1, 0, 0,   2, 30, 1,0,0,0);
    add("pause_tick",  0, 0,  0, 0, 1, 1,   2, 30, 0,1,0,0);
    run_table();
    for (int i = 1; i <= 5; i++)
      add($sformatf("paused_tk%0d", i), 0, 0, 0, 0, 0, 1, 2, 30, 0, 1, 0, 0);
    add("pause_again", 0, 0,  0, 0, 1, 0,   2, 30, 0,1,0,0);
    add("resume_tick", 0, 0,  0, 1, 0, 1,   2, 30, 1,0,0,0);
    add("dec_0229",    0, 0,  0, 0, 0, 1,   2, 29, 1,0,0,0);
    add("load_0005",   1, 0,  5, 0, 0, 0,   0,  5, 0,0,0,0);
    add("start_0005",  0, 0,  0, 1, 0, 0,   0,  5, 1,0,0,0);
    add("dec_0004",    0, 0,  0, 0, 0, 1,   0,  4, 1,0,0,0);
    add("load_tick",   1, 3,  0, 0, 0, 1,   3,  0, 0,0,0,0);
    add("load_start",  1, 0,  1, 1, 1, 1,   0,  1, 0,0,0,0);
    add("start_0001",  0, 0,  0, 1, 0, 0,   0,  1, 1,0,0,0);
    add("expire2",     0, 0,  0, 0, 0, 1,   0,  0, 0,0,1,1);
    add("ack_pause",   0, 0,  0, 0, 1, 1,   0,  0, 0,0,0,0);
    add("load_0001",   1, 0,  1, 0, 0, 0,   0,  1, 0,0,0,0);
    add("start_b",     0, 0,  0, 1, 0, 0,   0,  1, 1,0,0,0);
    add("expire3",     0, 0,  0, 0, 0, 1,   0,  0, 0,0,1,1);
    add("load_in_exp", 1, 0,  7, 0, 0, 1,   0,  7, 0,0,0,0);
    add("load_1010",   1, 10, 10, 0, 0, 0, 10, 10, 0,0,0,0);
    add("start_1010",  0, 0,  0, 1, 0, 0,  10, 10, 1,0,0,0);
    run_table();

    // Asynchronous reset mid-RUN, sampled between clock edges.
    #1 rst = 1'b1;
    #1 check("rst_mid_run", pack_exp(0, 0, 0, 0, 0, 0));
    $display("async rst mid-run -> %0d:%0d r=%b", min_out, sec_out, running);
    #1 rst = 1'b0;
    add("post_rst_st", 0, 0,  0, 1, 0, 1,   0,  0, 0,0,0,0);
    add("load_0001b",  1, 0,  1, 0, 0, 0,   0,  1, 0,0,0,0);
    add("start_c",     0, 0,  0, 1, 0, 0,   0,  1, 1,0,0,0);
    add("expire4",     0, 0,  0, 0, 0, 1,   0,  0, 0,0,1,1);
    run_table();

    // Asynchronous reset while expired and buzzing.
    #1 rst = 1'b1;
    #1 check("rst_mid_exp", pack_exp(0, 0, 0, 0, 0, 0));
    $display("async rst mid-expired -> d=%b b=%b", done, buzz);
    #1 rst = 1'b0;
    add("post_rst_tk", 0, 0,  0, 0, 0, 1,   0,  0, 0,0,0,0);
    add("post_rst_s2", 0, 0,  0, 1, 0, 0,   0,  0, 0,0,0,0);
    run_table();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
